// File: rtl/icache_dm.sv
// Direct-mapped, one-word-per-line instruction cache with whole-cache flush
// and saturating hit/miss counters.
module icache_dm #(
  parameter int unsigned SETS   = 16,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              imemREN,
  input  logic [ADDR_W-1:0] imemaddr,
  output logic              ihit,
  output logic [31:0]       imemload,
  input  logic              iflush,
  output logic              iREN,
  output logic [ADDR_W-1:0] iaddr,
  input  logic [31:0]       iload,
  input  logic              iwait,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count
);

  localparam int unsigned IDX_W  = $clog2(SETS);
  localparam int unsigned TAG_W  = ADDR_W - IDX_W - 2;
  localparam int unsigned LINE_W = ADDR_W - 2;

  typedef enum logic [0:0] {StIdle, StFill} state_e;

  state_e             state_q;
  logic [SETS-1:0]    valid_q;
  logic [TAG_W-1:0]   tag_q  [SETS];
  logic [31:0]        data_q [SETS];
  logic [LINE_W-1:0]  miss_line_q;
  logic               flush_pend_q;
  logic               iren_q;
  logic [CNT_W-1:0]   hit_cnt_q;
  logic [CNT_W-1:0]   miss_cnt_q;

  logic [IDX_W-1:0]   req_idx;
  logic [TAG_W-1:0]   req_tag;
  logic [LINE_W-1:0]  req_line;
  logic [IDX_W-1:0]   fill_idx;
  logic [TAG_W-1:0]   fill_tag;
  logic               lookup_hit;
  logic               lookup_miss;
  logic               fill_done;
  logic               fill_write;
  logic               fill_hit;
  logic               unused_offset;

  assign req_idx       = imemaddr[IDX_W+1:2];
  assign req_tag       = imemaddr[ADDR_W-1:IDX_W+2];
  assign req_line      = imemaddr[ADDR_W-1:2];
  assign fill_idx      = miss_line_q[IDX_W-1:0];
  assign fill_tag      = miss_line_q[LINE_W-1:IDX_W];
  assign unused_offset = ^imemaddr[1:0];

  assign lookup_hit  = (state_q == StIdle) && imemREN && valid_q[req_idx] &&
                       (tag_q[req_idx] == req_tag);
  assign lookup_miss = (state_q == StIdle) && imemREN && !lookup_hit;
  assign fill_done   = (state_q == StFill) && !iwait;
  // A flush seen at any point of the fill (including its last cycle) drops the line.
  assign fill_write  = fill_done && !(flush_pend_q || iflush);
  assign fill_hit    = fill_write && imemREN && (req_line == miss_line_q);

  assign ihit       = lookup_hit || fill_hit;
  assign iREN       = iren_q;
  assign iaddr      = {miss_line_q, 2'b00};
  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;

  always_comb begin
    imemload = '0;
    if (lookup_hit) begin
      imemload = data_q[req_idx];
    end else if (fill_hit) begin
      imemload = iload;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q      <= StIdle;
      valid_q      <= '0;
      miss_line_q  <= '0;
      flush_pend_q <= 1'b0;
      iren_q       <= 1'b0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (iflush) valid_q <= '0;
          if (lookup_hit && (hit_cnt_q != '1)) hit_cnt_q <= hit_cnt_q + CNT_W'(1);
          if (lookup_miss) begin
            miss_line_q <= req_line;
            iren_q      <= 1'b1;
            state_q     <= StFill;
            if (miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + CNT_W'(1);
          end
        end
        StFill: begin
          if (iflush) begin
            valid_q      <= '0;
            flush_pend_q <= 1'b1;
          end
          if (!iwait) begin
            if (fill_write) valid_q[fill_idx] <= 1'b1;
            flush_pend_q <= 1'b0;
            iren_q       <= 1'b0;
            state_q      <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Tag and data arrays carry no reset; only the valid bits matter after reset.
  always_ff @(posedge CLK) begin
    if (fill_write) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= iload;
    end
  end

endmodule
